// File: rtl/id_stage_param_pkg.sv
// id_stage_param_pkg: shared decode definitions for the parametrised MIPS decode stage.
//   - opcode / funct / REGIMM-rt constants
//   - instruction field slice helpers (rs, rt, rd, funct, imm16, imm26)
//   - decoder output encodings (branch condition, jump kind, extension mode, A3 select)
//   - TUSE_NONE (operand not read) and LINK_REG (r31)
package id_stage_param_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_BEQL    = 6'h14;
    localparam logic [5:0] OP_BNEL    = 6'h15;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [4:0] RI_BLTZ    = 5'h00;
    localparam logic [4:0] RI_BGEZ    = 5'h01;
    localparam logic [4:0] RI_BGEZAL  = 5'h11;

    localparam logic [1:0] TUSE_NONE  = 2'd3;
    localparam logic [4:0] LINK_REG   = 5'd31;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
    } br_cond_e;

    typedef enum logic [1:0] {
        JMP_NONE, JMP_J, JMP_JR
    } jmp_e;

    typedef enum logic [1:0] {
        EXT_SIGN, EXT_ZERO, EXT_LUI
    } ext_e;

    typedef enum logic [1:0] {
        A3_NONE, A3_RD, A3_RT, A3_LINK
    } a3_sel_e;

    function automatic logic [5:0]  f_op   (input logic [31:0] i); return i[31:26]; endfunction
    function automatic logic [4:0]  f_rs   (input logic [31:0] i); return i[25:21]; endfunction
    function automatic logic [4:0]  f_rt   (input logic [31:0] i); return i[20:16]; endfunction
    function automatic logic [4:0]  f_rd   (input logic [31:0] i); return i[15:11]; endfunction
    function automatic logic [5:0]  f_funct(input logic [31:0] i); return i[5:0];   endfunction
    function automatic logic [15:0] f_imm16(input logic [31:0] i); return i[15:0];  endfunction
    function automatic logic [25:0] f_imm26(input logic [31:0] i); return i[25:0];  endfunction

endpackage

// File: rtl/id_stage_param_ctrl.sv
// id_stage_param_ctrl: combinational instruction decoder for the decode stage.
// Inputs : op_i (opcode), rt_i (REGIMM sub-op), funct_i (SPECIAL function).
// Outputs: br_cond_o (br_cond_e), jmp_o (jmp_e), ext_o (ext_e), a3_sel_o (a3_sel_e),
//          link_o (writes d_pc+8), rs_tuse_o / rt_tuse_o (3 = operand not read).
// Macro  : ID_BRANCH_LIKELY_EN adds beql/bnel decoding; otherwise they are no-ops.
module id_stage_param_ctrl
    import id_stage_param_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [4:0] rt_i,
    input  logic [5:0] funct_i,
    output logic [2:0] br_cond_o,
    output logic [1:0] jmp_o,
    output logic [1:0] ext_o,
    output logic [1:0] a3_sel_o,
    output logic       link_o,
    output logic [1:0] rs_tuse_o,
    output logic [1:0] rt_tuse_o
);

    always_comb begin
        br_cond_o = BR_NONE;
        jmp_o     = JMP_NONE;
        ext_o     = EXT_SIGN;
        a3_sel_o  = A3_NONE;
        link_o    = 1'b0;
        rs_tuse_o = TUSE_NONE;
        rt_tuse_o = TUSE_NONE;
        case (op_i)
            OP_SPECIAL: begin
                case (funct_i)
                    FN_ADDU, FN_SUBU: begin
                        a3_sel_o  = A3_RD;
                        rs_tuse_o = 2'd1;
                        rt_tuse_o = 2'd1;
                    end
                    FN_JR: begin
                        jmp_o     = JMP_JR;
                        rs_tuse_o = 2'd0;
                    end
                    FN_JALR: begin
                        jmp_o     = JMP_JR;
                        a3_sel_o  = A3_RD;
                        link_o    = 1'b1;
                        rs_tuse_o = 2'd0;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt_i)
                    RI_BLTZ: begin
                        br_cond_o = BR_LTZ;
                        rs_tuse_o = 2'd0;
                    end
                    RI_BGEZ: begin
                        br_cond_o = BR_GEZ;
                        rs_tuse_o = 2'd0;
                    end
                    // bgezal links whether or not the branch is taken
                    RI_BGEZAL: begin
                        br_cond_o = BR_GEZ;
                        a3_sel_o  = A3_LINK;
                        link_o    = 1'b1;
                        rs_tuse_o = 2'd0;
                    end
                    default: ;
                endcase
            end
            OP_J: jmp_o = JMP_J;
            OP_JAL: begin
                jmp_o    = JMP_J;
                a3_sel_o = A3_LINK;
                link_o   = 1'b1;
            end
`ifdef ID_BRANCH_LIKELY_EN
            OP_BEQ, OP_BEQL: begin
`else
            OP_BEQ: begin
`endif
                br_cond_o = BR_EQ;
                rs_tuse_o = 2'd0;
                rt_tuse_o = 2'd0;
            end
`ifdef ID_BRANCH_LIKELY_EN
            OP_BNE, OP_BNEL: begin
`else
            OP_BNE: begin
`endif
                br_cond_o = BR_NE;
                rs_tuse_o = 2'd0;
                rt_tuse_o = 2'd0;
            end
            OP_BLEZ: begin
                br_cond_o = BR_LEZ;
                rs_tuse_o = 2'd0;
            end
            OP_BGTZ: begin
                br_cond_o = BR_GTZ;
                rs_tuse_o = 2'd0;
            end
            OP_ADDIU, OP_LW: begin
                a3_sel_o  = A3_RT;
                rs_tuse_o = 2'd1;
            end
            OP_ORI: begin
                ext_o     = EXT_ZERO;
                a3_sel_o  = A3_RT;
                rs_tuse_o = 2'd1;
            end
            OP_LUI: begin
                ext_o    = EXT_LUI;
                a3_sel_o = A3_RT;
            end
            OP_SW: begin
                rs_tuse_o = 2'd1;
                rt_tuse_o = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_param.sv
// id_stage_param: parametrised decode stage of a 5-stage MIPS pipeline.
// Holds the F/D register and the register file, selects forwarded operands, resolves
// branches/jumps and produces the next fetch PC.
// Ports:
//   clk, reset (async, active low)
//   f_pc/f_instr            fetched PC and instruction
//   d_stall/d_flush         hold / bubble the D register (stall wins)
//   fwd_r{s,t}_hit/_val     forwarded operands from later stages
//   w_we/w_a3/w_wd          register-file write port (write-through to reads)
//   d_pc/d_instr/d_valid    D register contents
//   d_rs_val/d_rt_val       operands after forwarding
//   d_a3/d_link_wd/d_signimm/d_rs_tuse/d_rt_tuse  decode results for E stage and hazard unit
//   npc/br_taken            next fetch PC and control-transfer flag
//   f_nullify               squash request for the delay slot of an untaken likely branch
// Macro: ID_BRANCH_LIKELY_EN enables beql/bnel and drives f_nullify; otherwise f_nullify = 0.
// NREG is expected to be >= 32 so that the 5-bit instruction fields and r31 are addressable.
module id_stage_param
    import id_stage_param_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          f_pc,
    input  logic [31:0]              f_instr,
    input  logic                     d_stall,
    input  logic                     d_flush,
    input  logic                     fwd_rs_hit,
    input  logic                     fwd_rt_hit,
    input  logic [XLEN-1:0]          fwd_rs_val,
    input  logic [XLEN-1:0]          fwd_rt_val,
    input  logic                     w_we,
    input  logic [$clog2(NREG)-1:0]  w_a3,
    input  logic [XLEN-1:0]          w_wd,
    output logic [XLEN-1:0]          d_pc,
    output logic [31:0]              d_instr,
    output logic                     d_valid,
    output logic [XLEN-1:0]          d_rs_val,
    output logic [XLEN-1:0]          d_rt_val,
    output logic [$clog2(NREG)-1:0]  d_a3,
    output logic [XLEN-1:0]          d_link_wd,
    output logic [XLEN-1:0]          d_signimm,
    output logic [1:0]               d_rs_tuse,
    output logic [1:0]               d_rt_tuse,
    output logic [XLEN-1:0]          npc,
    output logic                     br_taken,
    output logic                     f_nullify
);

    localparam int unsigned     AW       = $clog2(NREG);
    localparam logic [XLEN-1:0] PC_INC   = XLEN'(4);
    localparam logic [XLEN-1:0] LINK_INC = XLEN'(8);

    // ---------------- F/D register ----------------
    logic [XLEN-1:0] d_pc_q,    d_pc_d;
    logic [31:0]     d_instr_q, d_instr_d;
    logic            d_valid_q, d_valid_d;

    always_comb begin
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        if (!d_stall) begin
            if (d_flush) begin
                d_pc_d    = f_pc;
                d_instr_d = '0;
                d_valid_d = 1'b0;
            end else begin
                d_pc_d    = f_pc;
                d_instr_d = f_instr;
                d_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_pc_q    <= RESET_PC;
            d_instr_q <= '0;
            d_valid_q <= 1'b0;
        end else begin
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign d_pc    = d_pc_q;
    assign d_instr = d_instr_q;
    assign d_valid = d_valid_q;

    // ---------------- register file ----------------
    logic [XLEN-1:0] grf_q [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) grf_q[i] <= '0;
        end else if (w_we && (w_a3 != '0)) begin
            grf_q[w_a3] <= w_wd;
        end
    end

    logic [AW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [XLEN-1:0] rs_rf, rt_rf;

    assign rs_idx = AW'(f_rs(d_instr_q));
    assign rt_idx = AW'(f_rt(d_instr_q));
    assign rd_idx = AW'(f_rd(d_instr_q));

    // Write-through: a same-cycle write is visible to the read; r0 forced to zero
    // last so neither the bypass nor a forwarding hit can make it non-zero.
    always_comb begin
        rs_rf = grf_q[rs_idx];
        rt_rf = grf_q[rt_idx];
        if (w_we && (w_a3 == rs_idx)) rs_rf = w_wd;
        if (w_we && (w_a3 == rt_idx)) rt_rf = w_wd;
        d_rs_val = fwd_rs_hit ? fwd_rs_val : rs_rf;
        d_rt_val = fwd_rt_hit ? fwd_rt_val : rt_rf;
        if (rs_idx == '0) d_rs_val = '0;
        if (rt_idx == '0) d_rt_val = '0;
    end

    // ---------------- decode ----------------
    logic [2:0] br_cond;
    logic [1:0] jmp, ext_sel, a3_sel, rs_tuse, rt_tuse;
    logic       link;

    id_stage_param_ctrl u_ctrl (
        .op_i      (f_op(d_instr_q)),
        .rt_i      (f_rt(d_instr_q)),
        .funct_i   (f_funct(d_instr_q)),
        .br_cond_o (br_cond),
        .jmp_o     (jmp),
        .ext_o     (ext_sel),
        .a3_sel_o  (a3_sel),
        .link_o    (link),
        .rs_tuse_o (rs_tuse),
        .rt_tuse_o (rt_tuse)
    );

    logic [15:0] imm16;
    assign imm16 = f_imm16(d_instr_q);

    always_comb begin
        case (ext_sel)
            EXT_ZERO: d_signimm = XLEN'(imm16);
            EXT_LUI:  d_signimm = XLEN'({imm16, 16'h0000});
            default:  d_signimm = XLEN'($signed(imm16));
        endcase
    end

    always_comb begin
        case (a3_sel)
            A3_RD:   d_a3 = rd_idx;
            A3_RT:   d_a3 = rt_idx;
            A3_LINK: d_a3 = AW'(LINK_REG);
            default: d_a3 = '0;
        endcase
        if (!d_valid_q) d_a3 = '0;
    end

    assign d_link_wd = (d_valid_q && link) ? d_pc_q + LINK_INC : '0;
    assign d_rs_tuse = d_valid_q ? rs_tuse : TUSE_NONE;
    assign d_rt_tuse = d_valid_q ? rt_tuse : TUSE_NONE;

    // ---------------- branch / jump resolution ----------------
    logic            rs_neg, rs_zero, cond_met, taken;
    logic [XLEN-1:0] pc4, br_target, j_target, target;

    assign rs_neg  = d_rs_val[XLEN-1];
    assign rs_zero = (d_rs_val == '0);

    always_comb begin
        case (br_cond)
            BR_EQ:   cond_met = (d_rs_val == d_rt_val);
            BR_NE:   cond_met = (d_rs_val != d_rt_val);
            BR_LEZ:  cond_met = rs_neg | rs_zero;
            BR_GTZ:  cond_met = ~rs_neg & ~rs_zero;
            BR_LTZ:  cond_met = rs_neg;
            BR_GEZ:  cond_met = ~rs_neg;
            default: cond_met = 1'b0;
        endcase
    end

    assign pc4       = d_pc_q + PC_INC;
    assign br_target = pc4 + XLEN'($signed({imm16, 2'b00}));
    assign j_target  = {pc4[XLEN-1:28], f_imm26(d_instr_q), 2'b00};

    always_comb begin
        case (jmp)
            JMP_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            JMP_JR: begin
                taken  = 1'b1;
                target = d_rs_val;
            end
            default: begin
                taken  = cond_met;
                target = br_target;
            end
        endcase
        if (!d_valid_q) taken = 1'b0;
    end

    // npc ignores d_stall: the fetch PC register gates its own update.
    assign br_taken = taken;
    assign npc      = taken ? target : f_pc + PC_INC;

`ifdef ID_BRANCH_LIKELY_EN
    logic likely;
    assign likely    = (f_op(d_instr_q) == OP_BEQL) || (f_op(d_instr_q) == OP_BNEL);
    assign f_nullify = d_valid_q & likely & ~cond_met;
`else
    assign f_nullify = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_param.sv
// tb_id_stage_param: randomized + directed bench for id_stage_param with a scoreboard.
// The driver applies inputs just after each rising edge, advances a behavioural model
// of the decode stage and pushes the expected outputs; a monitor compares at falling edges.
module tb_id_stage_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc, f_instr;
    logic        d_stall, d_flush;
    logic        fwd_rs_hit, fwd_rt_hit;
    logic [31:0] fwd_rs_val, fwd_rt_val;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_link_wd, d_signimm, npc;
    logic        d_valid, br_taken, f_nullify;
    logic [4:0]  d_a3;
    logic [1:0]  d_rs_tuse, d_rt_tuse;

    id_stage_param #(.XLEN(32), .NREG(32), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_instr(f_instr),
        .d_stall(d_stall), .d_flush(d_flush),
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
        .fwd_rs_val(fwd_rs_val), .fwd_rt_val(fwd_rt_val),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd),
        .d_pc(d_pc), .d_instr(d_instr), .d_valid(d_valid),
        .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_a3(d_a3),
        .d_link_wd(d_link_wd), .d_signimm(d_signimm),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .npc(npc), .br_taken(br_taken), .f_nullify(f_nullify)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reset, stall, flush, rs_hit, rt_hit, we;
        logic [31:0] f_pc, f_instr, rs_fv, rt_fv, wd;
        logic [4:0]  a3;
    } in_t;

    typedef struct {
        logic [31:0] pc, instr, rs, rt, link, imm, npc;
        logic        valid, taken, nul;
        logic [4:0]  a3;
        logic [1:0]  rsu, rtu;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    logic [31:0] m_grf [32];
    in_t         cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s.reset = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
        s.rs_hit = 1'b0; s.rt_hit = 1'b0; s.we = 1'b0;
        s.f_pc = 32'h0000_2000; s.f_instr = 32'h0;
        s.rs_fv = 32'h0; s.rt_fv = 32'h0; s.wd = 32'h0; s.a3 = 5'd0;
        return s;
    endfunction

    task automatic drive();
        reset = cur.reset; f_pc = cur.f_pc; f_instr = cur.f_instr;
        d_stall = cur.stall; d_flush = cur.flush;
        fwd_rs_hit = cur.rs_hit; fwd_rt_hit = cur.rt_hit;
        fwd_rs_val = cur.rs_fv; fwd_rt_val = cur.rt_fv;
        w_we = cur.we; w_a3 = cur.a3; w_wd = cur.wd;
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_instr = 32'h0; m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
    endtask

    function automatic logic [31:0] rd_op(input logic [4:0] idx, input logic hit, input logic [31:0] fv);
        if (idx == 5'd0) return 32'h0;
        if (hit) return fv;
        if (cur.we && cur.a3 == idx) return cur.wd;
        return m_grf[idx];
    endfunction

    // Expected outputs for the current model state and the inputs now applied.
    function automatic exp_t model_out();
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] a, b, sx, pc4, btgt, tgt;
        logic        link, take, likely;
        op = m_instr[31:26]; fn = m_instr[5:0];
        rs = m_instr[25:21]; rt = m_instr[20:16]; rd = m_instr[15:11];
        imm = m_instr[15:0];
        a = rd_op(rs, cur.rs_hit, cur.rs_fv);
        b = rd_op(rt, cur.rt_hit, cur.rt_fv);
        sx = {{16{imm[15]}}, imm};
        pc4 = m_pc + 32'd4;
        btgt = pc4 + (sx << 2);
        tgt = btgt; link = 1'b0; take = 1'b0; likely = 1'b0;
        e.pc = m_pc; e.instr = m_instr; e.valid = m_valid;
        e.rs = a; e.rt = b; e.imm = sx; e.a3 = 5'd0; e.rsu = 2'd3; e.rtu = 2'd3;
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h23) begin e.a3 = rd; e.rsu = 2'd1; e.rtu = 2'd1; end
                else if (fn == 6'h08) begin take = 1'b1; tgt = a; e.rsu = 2'd0; end
                else if (fn == 6'h09) begin take = 1'b1; tgt = a; e.rsu = 2'd0; e.a3 = rd; link = 1'b1; end
            end
            6'h01: begin
                if (rt == 5'h00) begin e.rsu = 2'd0; take = $signed(a) < 32'sd0; end
                if (rt == 5'h01) begin e.rsu = 2'd0; take = $signed(a) >= 32'sd0; end
                if (rt == 5'h11) begin e.rsu = 2'd0; take = $signed(a) >= 32'sd0; link = 1'b1; e.a3 = 5'd31; end
            end
            6'h02: begin take = 1'b1; tgt = {pc4[31:28], m_instr[25:0], 2'b00}; end
            6'h03: begin take = 1'b1; tgt = {pc4[31:28], m_instr[25:0], 2'b00}; link = 1'b1; e.a3 = 5'd31; end
            6'h04: begin take = (a == b); e.rsu = 2'd0; e.rtu = 2'd0; end
            6'h05: begin take = (a != b); e.rsu = 2'd0; e.rtu = 2'd0; end
`ifdef ID_BRANCH_LIKELY_EN
            6'h14: begin take = (a == b); likely = 1'b1; e.rsu = 2'd0; e.rtu = 2'd0; end
            6'h15: begin take = (a != b); likely = 1'b1; e.rsu = 2'd0; e.rtu = 2'd0; end
`endif
            6'h06: begin take = $signed(a) <= 32'sd0; e.rsu = 2'd0; end
            6'h07: begin take = $signed(a) > 32'sd0;  e.rsu = 2'd0; end
            6'h09, 6'h23: begin e.a3 = rt; e.rsu = 2'd1; end
            6'h0D: begin e.imm = {16'h0, imm}; e.a3 = rt; e.rsu = 2'd1; end
            6'h0F: begin e.imm = {imm, 16'h0}; e.a3 = rt; end
            6'h2B: begin e.rsu = 2'd1; e.rtu = 2'd2; end
            default: ;
        endcase
        if (!m_valid) begin take = 1'b0; link = 1'b0; likely = 1'b0; e.a3 = 5'd0; end
        e.link  = link ? m_pc + 32'd8 : 32'h0;
        e.taken = take;
        e.npc   = take ? tgt : cur.f_pc + 32'd4;
        e.nul   = likely && !take;
        return e;
    endfunction

    // One clock: account for the edge with the old inputs, then apply new ones.
    task automatic step(input in_t s);
        @(posedge clk);
        #1;
        if (cur.reset) begin
            if (cur.we && cur.a3 != 5'd0) m_grf[cur.a3] = cur.wd;
            if (!cur.stall) begin
                m_pc = cur.f_pc;
                m_instr = cur.flush ? 32'h0 : cur.f_instr;
                m_valid = !cur.flush;
            end
        end
        cur = s;
        drive();
        if (!cur.reset) model_reset();
        q.push_back(model_out());
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("d_pc", d_pc, e.pc);
                chk("d_instr", d_instr, e.instr);
                chk("d_valid", {31'h0, d_valid}, {31'h0, e.valid});
                chk("d_rs_val", d_rs_val, e.rs);
                chk("d_rt_val", d_rt_val, e.rt);
                chk("d_a3", {27'h0, d_a3}, {27'h0, e.a3});
                chk("d_link_wd", d_link_wd, e.link);
                chk("d_signimm", d_signimm, e.imm);
                chk("d_rs_tuse", {30'h0, d_rs_tuse}, {30'h0, e.rsu});
                chk("d_rt_tuse", {30'h0, d_rt_tuse}, {30'h0, e.rtu});
                chk("npc", npc, e.npc);
                chk("br_taken", {31'h0, br_taken}, {31'h0, e.taken});
                chk("f_nullify", {31'h0, f_nullify}, {31'h0, e.nul});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8;
            4: return 32'h8000_0000;
            5: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] r;
        rs = rreg(); rt = rreg(); rd = rreg(); imm = 16'($urandom); r = $urandom;
        case ($urandom_range(0, 21))
            0:  return rtype(6'h21, rs, rt, rd);
            1:  return rtype(6'h23, rs, rt, rd);
            2:  return rtype(6'h08, rs, rt, rd);
            3:  return rtype(6'h09, rs, rt, rd);
            4:  return itype(6'h01, rs, 5'h00, imm);
            5:  return itype(6'h01, rs, 5'h01, imm);
            6:  return itype(6'h01, rs, 5'h11, imm);
            7:  return {6'h02, r[25:0]};
            8:  return {6'h03, r[25:0]};
            9:  return itype(6'h04, rs, rt, imm);
            10: return itype(6'h05, rs, rt, imm);
            11: return itype(6'h06, rs, rt, imm);
            12: return itype(6'h07, rs, rt, imm);
            13: return itype(6'h09, rs, rt, imm);
            14: return itype(6'h0D, rs, rt, imm);
            15: return itype(6'h0F, rs, rt, imm);
            16: return itype(6'h23, rs, rt, imm);
            17: return itype(6'h2B, rs, rt, imm);
            18: return itype(6'h14, rs, rt, imm);
            19: return itype(6'h15, rs, rt, imm);
            20: return r;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        in_t s;
        logic exp_nul;
        cur = idle();
        cur.reset = 1'b0;
        drive();
        model_reset();

        // reset held for two cycles, then released with D stalled
        s = idle(); s.reset = 1'b0;
        step(s); step(s);
        s = idle(); s.stall = 1'b1; s.f_pc = 32'h0000_1000;
        step(s);
        @(negedge clk);
        chk("rst_d_pc", d_pc, 32'h0000_3000);
        chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
        chk("rst_rs", d_rs_val, 32'h0);
        chk("rst_npc", npc, 32'h0000_1004);

        // seed r7 = 5, r3 = -1
        s = idle(); s.we = 1'b1; s.a3 = 5'd7; s.wd = 32'h5; step(s);
        s = idle(); s.we = 1'b1; s.a3 = 5'd3; s.wd = 32'hFFFF_FFFF; step(s);

        // write-through bypass into an addu reading r5
        s = idle(); s.f_pc = 32'h0000_3000; s.f_instr = rtype(6'h21, 5'd5, 5'd6, 5'd9); step(s);
        s = idle(); s.stall = 1'b1; s.we = 1'b1; s.a3 = 5'd5; s.wd = 32'hDEAD_BEEF; step(s);
        @(negedge clk);
        chk("bypass_rs", d_rs_val, 32'hDEAD_BEEF);
        chk("addu_a3", {27'h0, d_a3}, 32'd9);

        // r0 ignores writes and forwarding
        s = idle(); s.f_instr = rtype(6'h21, 5'd0, 5'd5, 5'd9); s.we = 1'b1; s.a3 = 5'd5; s.wd = 32'hDEAD_BEEF; step(s);
        s = idle(); s.stall = 1'b1; s.we = 1'b1; s.a3 = 5'd0; s.wd = 32'h1234_5678;
        s.rs_hit = 1'b1; s.rs_fv = 32'h55; step(s);
        @(negedge clk);
        chk("r0_read", d_rs_val, 32'h0);
        chk("r5_read", d_rt_val, 32'hDEAD_BEEF);
        s = idle(); s.stall = 1'b1; step(s);

        // beq taken backwards, then defeated by forwarding
        s = idle(); s.f_pc = 32'h0000_3004; s.f_instr = itype(6'h04, 5'd7, 5'd7, 16'hFFFE); step(s);
        s = idle(); s.stall = 1'b1; s.f_pc = 32'h0000_3010; step(s);
        @(negedge clk);
        chk("beq_npc", npc, 32'h0000_3000);
        chk("beq_taken", {31'h0, br_taken}, 32'h1);
        s.rt_hit = 1'b1; s.rt_fv = 32'h8; step(s);
        @(negedge clk);
        chk("beq_fwd_npc", npc, 32'h0000_3014);
        chk("beq_fwd_taken", {31'h0, br_taken}, 32'h0);

        // bgezal not taken still links
        s = idle(); s.f_pc = 32'h0000_3100; s.f_instr = itype(6'h01, 5'd3, 5'h11, 16'h0010); step(s);
        s = idle(); s.stall = 1'b1; step(s);
        @(negedge clk);
        chk("bgezal_taken", {31'h0, br_taken}, 32'h0);
        chk("bgezal_a3", {27'h0, d_a3}, 32'd31);
        chk("bgezal_link", d_link_wd, 32'h0000_3108);

        // stall beats flush, then flush alone
        s = idle(); s.f_pc = 32'h0000_3200; s.f_instr = rtype(6'h21, 5'd1, 5'd2, 5'd9); step(s);
        s = idle(); s.stall = 1'b1; step(s);
        s = idle(); s.stall = 1'b1; s.flush = 1'b1; s.f_pc = 32'h0000_3F00;
        step(s); step(s); step(s);
        s = idle(); s.flush = 1'b1; s.f_pc = 32'h0000_3300; step(s);
        @(negedge clk);
        chk("stall_pc", d_pc, 32'h0000_3200);
        chk("stall_valid", {31'h0, d_valid}, 32'h1);
        s = idle(); s.stall = 1'b1; step(s);
        @(negedge clk);
        chk("flush_valid", {31'h0, d_valid}, 32'h0);
        chk("flush_instr", d_instr, 32'h0);
        chk("flush_a3", {27'h0, d_a3}, 32'h0);
        chk("flush_pc", d_pc, 32'h0000_3300);

        // bnel with rs == rt: not taken
        s = idle(); s.f_pc = 32'h0000_3400; s.f_instr = itype(6'h15, 5'd7, 5'd7, 16'h0004); step(s);
        s = idle(); s.stall = 1'b1; s.f_pc = 32'h0000_3500; step(s);
        @(negedge clk);
`ifdef ID_BRANCH_LIKELY_EN
        exp_nul = 1'b1;
`else
        exp_nul = 1'b0;
`endif
        chk("bnel_nullify", {31'h0, f_nullify}, {31'h0, exp_nul});
        chk("bnel_npc", npc, 32'h0000_3504);

        // reset in mid-operation
        s = idle(); s.reset = 1'b0; step(s);
        @(negedge clk);
        chk("midrst_valid", {31'h0, d_valid}, 32'h0);
        chk("midrst_pc", d_pc, 32'h0000_3000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            s.reset   = ($urandom_range(0, 99) != 0);
            s.stall   = ($urandom_range(0, 99) < 15);
            s.flush   = ($urandom_range(0, 99) < 10);
            s.f_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            s.f_instr = rand_instr();
            s.rs_hit  = ($urandom_range(0, 99) < 20);
            s.rt_hit  = ($urandom_range(0, 99) < 20);
            s.rs_fv   = rval();
            s.rt_fv   = rval();
            s.we      = ($urandom_range(0, 1) == 1);
            s.a3      = rreg();
            s.wd      = rval();
            step(s);
        end
        s = idle(); step(s); step(s);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline.
- Owns the F/D pipeline register, the register file, forward-mux selection, the branch comparator (6 conditions plus linking bgezal) and next-PC generation.
- Emits operands, A3, link data, extended immediate and Tuse to the E-stage register and the hazard unit.
- Generalises the fixed 32-bit/32-register decode to parametrised width and register count, adds stall/flush handling and write-bypass.

Parameters:
- XLEN, 32, datapath and PC width (>=32).
- NREG, 32, register count; AW = $clog2(NREG); r0 hardwired to zero, r31 is the link register.
- RESET_PC, 32'h0000_3000, D-register PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- f_pc  in  XLEN  PC of the fetched instruction.
- f_instr  in  32  fetched instruction.
- d_stall  in  1  hazard unit: hold the D register.
- d_flush  in  1  insert bubble into the D register.
- fwd_rs_hit, fwd_rt_hit  in  1  forwarded value is valid.
- fwd_rs_val, fwd_rt_val  in  XLEN  forwarded operand values.
- w_we  in  1  write-back enable.
- w_a3  in  AW  write-back register index.
- w_wd  in  XLEN  write-back data.
- d_pc  out  XLEN  registered PC.
- d_instr  out  32  registered instruction.
- d_valid  out  1  D slot holds a real instruction.
- d_rs_val, d_rt_val  out  XLEN  operands after forwarding.
- d_a3  out  AW  destination register (0 = none).
- d_link_wd  out  XLEN  d_pc+8 for link instructions, else 0.
- d_signimm  out  XLEN  extended imm16.
- d_rs_tuse, d_rt_tuse  out  2  Tuse (3 = unused).
- npc  out  XLEN  next fetch PC.
- br_taken  out  1  control transfer resolved taken.
- f_nullify  out  1  optional-feature output; constant 0 when the feature is off.

Behaviour:
- D register reset (reset=0, async): d_pc=RESET_PC, d_instr=0, d_valid=0. All GRF entries are 0.
- Every rising edge, in priority order:
  - d_stall=1: hold all D state.
  - else d_flush=1: d_instr=0, d_valid=0, d_pc=f_pc.
  - else load f_pc/f_instr and set d_valid=1.
- Stall beats flush when both are asserted.
- Latency: 1 cycle from f_* to d_*. All other outputs are combinational from D state.
- GRF write:
  - Occurs on the edge when w_we=1 and w_a3!=0. Writes to r0 are ignored.
  - A read of index w_a3 while w_we=1 returns w_wd in the same cycle (write-through bypass).
- Operand select: fwd_*_hit=1 selects fwd_*_val, else the GRF/bypass value. Index 0 always yields 0 regardless of hit.
- Immediate: sign-extended for beq/bne/b*z/addiu/lw/sw; zero-extended for ori. lui yields {imm16,16'b0} zero-padded to XLEN.
- Branches:
  - Compare on d_rs_val (and d_rt_val), signed.
  - Conditions: beq (eq), bne (ne), blez (<=0), bgtz (>0), bltz (<0), bgez (>=0), bgezal (>=0).
  - Target = d_pc + 4 + (sext(imm16)<<2), modulo 2^XLEN.
- bgezal: always links. d_a3=31 and d_link_wd=d_pc+8, taken or not.
- Jumps:
  - j/jal target = {(d_pc+4)[XLEN-1:28], index26, 2'b00}.
  - jr/jalr target = d_rs_val.
  - jal writes 31; jalr writes rd.
- npc:
  - taken branch or jump: target, br_taken=1.
  - otherwise: f_pc+4.
  - d_valid=0 forces not-taken.
  - d_stall does not alter npc; the PC register gates itself.
- d_a3 selection:
  - rd for addu/subu/jalr.
  - rt for ori/lui/lw/addiu.
  - 31 for jal/bgezal.
  - 0 for all other instructions and whenever d_valid=0.
- Tuse:
  - rs: 0 for branches/jr/jalr; 1 for ALU/load/store; 3 if rs unused.
  - rt: 0 for beq/bne; 1 for addu/subu; 2 for sw; 3 otherwise.
- Delay slot: always executed (no nullify) unless the optional feature is enabled.
- Reset mid-operation: D state and GRF clear immediately; outputs reflect a bubble.

Optional Feature:
- Macro: ID_BRANCH_LIKELY_EN.
- Defined:
  - Also decodes beql/bnel (opcodes 0x14/0x15) with the same compare and target as beq/bne.
  - When such a branch is not taken and d_valid=1, f_nullify=1. The hazard unit then drives d_flush next edge, squashing the delay slot.
- Undefined: those opcodes decode as no-ops (d_a3=0, Tuse=3) and f_nullify is tied 0.

Decomposition:
- Shared package/macros: opcode/funct constants, instruction field slices (rs, rt, rd, imm16, imm26), TUSE_NONE=3, LINK_REG=31.
- Natural sub-module: id_ctrl (combinational decoder). It produces the branch condition code, jump kind, ext mode, A3 select, link flag and Tuse.
- The GRF and D register stay inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> d_pc=32'h3000, d_valid=0, rs/rt read 0, npc=f_pc+4.
- Bypass: w_we=1, w_a3=5, w_wd=32'hDEAD_BEEF while D holds addu with rs=5 -> d_rs_val=DEADBEEF same cycle. Write to r0 -> reads stay 0.
- beq taken: d_pc=32'h3004, rs=rt=7, imm16=16'hFFFE -> npc=32'h3000, br_taken=1. Same instruction with fwd_rt_hit=1 and fwd_rt_val=8 -> npc=f_pc+4.
- bgezal not taken: rs=-1 -> br_taken=0, d_a3=31, d_link_wd=d_pc+8.
- Stall/flush: d_stall=1 and d_flush=1 together for 3 cycles -> D unchanged. Then flush alone -> d_instr=0, d_valid=0, d_a3=0.
- Feature ID_BRANCH_LIKELY_EN: bnel with rs==rt -> f_nullify=1, npc=f_pc+4. Same stimulus with the macro undefined -> f_nullify=0.
